fc_act_loader: RTL and testbench

- Feeds one fully-connected layer neuron (combinational booth-multiplier/adder-tree/ReLU block) and collects its result.
- Input side: deserialises a valid/ready stream of WIDTH-bit activations into the IN-entry vector the layer consumes, and holds that vector stable.
- Output side: waits a fixed settle time, captures the wide ReLU output z, requantises it to WIDTH bits, and presents it on a valid/ready stream.
- This lets fc layers run as a streaming pipeline stage instead of a fully parallel wire bundle.

---
 rtl/fc_pkg.sv | 16 +
 rtl/fc_requant.sv | 22 ++
 rtl/fc_act_loader.sv | 106 ++++++++++
 tb/tb_fc_act_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared constants and state type for the fc activation loader
package fc_pkg;
   localparam int WIDTH  = 8;
   localparam int IN     = 128;
   localparam int ZW     = 23;
   localparam int SHIFT  = 7;
   localparam int SETTLE = 2;
   localparam int IDX_W  = $clog2(IN);
   localparam int SET_W  = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {
      ST_FILL,
      ST_SETTLE,
      ST_OUT
   } state_t;
endpackage

// File: rtl/fc_requant.sv
// rtl/fc_requant.sv - round-half-up right shift of z with unsigned saturation to WIDTH bits
module fc_requant #(
   parameter int ZW    = 23,
   parameter int WIDTH = 8,
   parameter int SHIFT = 7
) (
   input  logic [ZW-1:0]    z,
   output logic [WIDTH-1:0] q
);
   localparam logic [ZW:0] RND  = (ZW+1)'(1) << (SHIFT - 1);
   localparam logic [ZW:0] MAXV = {{(ZW+1-WIDTH){1'b0}}, {WIDTH{1'b1}}};

   logic [ZW:0] sum;
   logic [ZW:0] t;

   // One extra bit keeps the rounding add from wrapping at z = 2^ZW-1
   always_comb begin
      sum = {1'b0, z} + RND;
      t   = sum >> SHIFT;
      q   = (t > MAXV) ? {WIDTH{1'b1}} : t[WIDTH-1:0];
   end
endmodule

// File: rtl/fc_act_loader.sv
// rtl/fc_act_loader.sv - deserialises activations into the layer input vector and streams out the requantised result
module fc_act_loader
   import fc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_last,
   output logic [WIDTH-1:0] x [0:IN-1],
   input  logic [ZW-1:0]    z,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             err_len
);
   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [SET_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] buf_q [0:IN-1];
   logic [WIDTH-1:0] buf_d [0:IN-1];
   logic             m_valid_q, m_valid_d;
   logic [WIDTH-1:0] m_data_q, m_data_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] q;

   fc_requant #(.ZW(ZW), .WIDTH(WIDTH), .SHIFT(SHIFT)) u_requant (
      .z (z),
      .q (q)
   );

   assign x       = buf_q;
   assign s_ready = rst_n && (state_q == ST_FILL);
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign err_len = err_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      buf_d     = buf_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      err_d     = 1'b0;
      case (state_q)
         ST_FILL: begin
            if (s_valid && s_ready) begin
               buf_d[idx_q] = s_data;
               if (idx_q == IDX_W'(IN - 1)) begin
                  err_d   = !s_last;
                  idx_d   = '0;
                  state_d = ST_SETTLE;
               end else if (s_last) begin
                  // Short frame: clear the tail so stale activations never reach the layer
                  for (int j = 0; j < IN; j++) begin
                     if (j > int'(idx_q)) buf_d[j] = '0;
                  end
                  err_d   = 1'b1;
                  idx_d   = '0;
                  state_d = ST_SETTLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_SETTLE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SET_W'(SETTLE - 1)) begin
               cnt_d     = '0;
               m_valid_d = 1'b1;
               m_data_d  = q;
               state_d   = ST_OUT;
            end
         end
         ST_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = ST_FILL;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_FILL;
         idx_q     <= '0;
         cnt_q     <= '0;
         buf_q     <= '{default: '0};
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         buf_q     <= buf_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         err_q     <= err_d;
      end
   end
endmodule

// File: tb/tb_fc_act_loader.sv
// tb/tb_fc_act_loader.sv - self-checking bench for fc_act_loader
module tb_fc_act_loader;
   import fc_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             s_last;
   logic [WIDTH-1:0] x [0:IN-1];
   logic [ZW-1:0]    z;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             err_len;

   int n_chk  = 0;
   int n_fail = 0;
   int err_cnt = 0;
   logic [WIDTH-1:0] sb [$];

   typedef struct {
      logic [ZW-1:0]    zv;
      logic [WIDTH-1:0] exp;
   } vec_t;
   vec_t vecs [0:6];

   fc_act_loader dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .x       (x),
      .z       (z),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .err_len (err_len)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rst_n && err_len) err_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int len, input logic [WIDTH-1:0] val, input bit with_last);
      for (int i = 0; i < len; i++) begin
         int w = 0;
         s_valid = 1'b1;
         s_data  = val;
         s_last  = with_last && (i == len - 1);
         while (!s_ready && w < 200) begin
            step();
            w++;
         end
         if (w == 200) check("s_ready_timeout", 0, 1);
         step();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_result(input string name);
      int lat = 0;
      logic [WIDTH-1:0] e;
      while (!m_valid && lat < 50) begin
         step();
         lat++;
      end
      check({name, "_latency"}, lat, SETTLE);
      e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      check({name, "_m_data"}, m_data, e);
   endtask

   task automatic handshake(input string name);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check({name, "_m_valid_fall"}, m_valid, 0);
      check({name, "_s_ready_back"}, s_ready, 1);
   endtask

   task automatic count_x(input logic [WIDTH-1:0] head, input int nhead, output int bad);
      bad = 0;
      for (int i = 0; i < IN; i++) begin
         if (x[i] !== ((i < nhead) ? head : '0)) bad++;
      end
   endtask

   initial begin
      int bad;
      int e0;
      vecs[0] = '{zv: 23'd1000,    exp: 8'd8};
      vecs[1] = '{zv: 23'd63,      exp: 8'd0};
      vecs[2] = '{zv: 23'd64,      exp: 8'd1};
      vecs[3] = '{zv: 23'd191,     exp: 8'd1};
      vecs[4] = '{zv: 23'd192,     exp: 8'd2};
      vecs[5] = '{zv: 23'd40000,   exp: 8'd255};
      vecs[6] = '{zv: 23'h7FFFFF,  exp: 8'd255};

      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; z = '0; m_ready = 1'b0;
      step(); step();
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_err_len", err_len, 0);
      count_x(8'd0, 0, bad);
      check("rst_x_zero", bad, 0);
      rst_n = 1'b1;
      step();
      check("post_rst_s_ready", s_ready, 1);

      // Requantisation vectors, each through a full well-formed frame
      for (int v = 0; v < 7; v++) begin
         z = vecs[v].zv;
         e0 = err_cnt;
         sb.push_back(vecs[v].exp);
         send_frame(IN, 8'd1, 1'b1);
         if (v == 0) begin
            count_x(8'd1, IN, bad);
            check("full_x_ones", bad, 0);
         end
         wait_result($sformatf("vec%0d", v));
         handshake($sformatf("vec%0d", v));
         check($sformatf("vec%0d_no_err", v), err_cnt - e0, 0);
      end

      // Backpressure: output held while z moves underneath it
      z = 23'd500;
      sb.push_back(8'd4);
      send_frame(IN, 8'd3, 1'b1);
      wait_result("bp");
      z = 23'd0;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (m_valid !== 1'b1 || m_data !== 8'd4 || s_ready !== 1'b0) bad++;
      end
      check("bp_held_cycles_bad", bad, 0);
      handshake("bp");

      // Early last after a frame of all 0xFF
      z = 23'd1000;
      sb.push_back(8'd8);
      send_frame(IN, 8'hFF, 1'b1);
      wait_result("ff");
      handshake("ff");
      e0 = err_cnt;
      sb.push_back(8'd8);
      send_frame(5, 8'd9, 1'b1);
      count_x(8'd9, 5, bad);
      check("early_x_pad", bad, 0);
      wait_result("early");
      check("early_err_pulses", err_cnt - e0, 1);
      handshake("early");

      // Missing last on beat IN-1
      e0 = err_cnt;
      sb.push_back(8'd8);
      send_frame(IN, 8'd2, 1'b0);
      wait_result("nolast");
      check("nolast_err_pulses", err_cnt - e0, 1);
      handshake("nolast");

      // Reset mid-FILL at idx=60
      send_frame(60, 8'd7, 1'b0);
      rst_n = 1'b0;
      step();
      check("midfill_s_ready", s_ready, 0);
      check("midfill_m_valid", m_valid, 0);
      count_x(8'd0, 0, bad);
      check("midfill_x_zero", bad, 0);
      rst_n = 1'b1;
      step();

      // Reset during OUT discards the pending result
      z = 23'd192;
      sb.push_back(8'd2);
      send_frame(IN, 8'd5, 1'b1);
      wait_result("midout");
      rst_n = 1'b0;
      step();
      check("midout_m_valid", m_valid, 0);
      check("midout_m_data", m_data, 0);
      count_x(8'd0, 0, bad);
      check("midout_x_zero", bad, 0);
      rst_n = 1'b1;
      step();

      z = 23'd1000;
      sb.push_back(8'd8);
      send_frame(IN, 8'd1, 1'b1);
      count_x(8'd1, IN, bad);
      check("after_rst_x", bad, 0);
      wait_result("after_rst");
      handshake("after_rst");
      check("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
